// File: rtl/four_bit_multiplier_pkg.sv
`default_nettype none
// ============================================================================
// Module      : four_bit_multiplier_pkg
// Description : Shared widths and constants for the 4x4 unsigned array
//               multiplier (operand width, product width, reset value and
//               the largest representable product).
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package four_bit_multiplier_pkg;

   localparam int                   OPERAND_W     = 4;
   localparam int                   PRODUCT_W     = 8;
   localparam logic [PRODUCT_W-1:0] PRODUCT_RESET = 8'h00;
   localparam logic [PRODUCT_W-1:0] PRODUCT_MAX   = 8'd225;

endpackage : four_bit_multiplier_pkg
`default_nettype wire

// File: rtl/four_bit_multiplier_if.sv
`default_nettype none
// ============================================================================
// Module      : four_bit_multiplier_if
// Description : Bundles the multiplier operands and product so a driver and
//               an observer can share one handle. The multiplier itself keeps
//               its bit-level ports; this bundle is wired to them bit by bit.
// Ports       : a, b    - operands (master drives)
//               product - registered product (slave drives)
// Revision    : 1.0 - initial release
// ============================================================================
interface four_bit_multiplier_if;
   import four_bit_multiplier_pkg::*;

   logic [OPERAND_W-1:0] a;
   logic [OPERAND_W-1:0] b;
   // A net, so the eight individual product pins can each drive one bit.
   wire  [PRODUCT_W-1:0] product;

   modport master (output a, output b, input  product);
   modport slave  (input  a, input  b, output product);

endinterface : four_bit_multiplier_if
`default_nettype wire

// File: rtl/mult_full_adder.sv
`default_nettype none
// ============================================================================
// Module      : mult_full_adder
// Description : One-bit full adder cell of the multiplier array. Used as a
//               half adder by tying i_cin to 0.
// Ports       : i_a, i_b, i_cin - addend bits and carry in
//               o_sum, o_cout    - sum bit and carry out
// Revision    : 1.0 - initial release
// ============================================================================
module mult_full_adder (
   input  logic i_a,
   input  logic i_b,
   input  logic i_cin,
   output logic o_sum,
   output logic o_cout
);

   logic w_axb;

   assign w_axb  = i_a ^ i_b;
   assign o_sum  = w_axb ^ i_cin;
   assign o_cout = (i_a & i_b) | (i_cin & w_axb);

endmodule : mult_full_adder
`default_nettype wire

// File: rtl/four_bit_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : four_bit_multiplier
// Description : Unsigned 4x4 -> 8 bit array multiplier with a registered
//               product. 16 AND partial products are reduced by a 3-row
//               adder array (4 half adders, 8 full adders).
// Ports       : clk              - rising-edge clock
//               rst_n            - asynchronous active-low reset
//               A0..A3           - operand A, bit 0 is LSB
//               B0..B3           - operand B, bit 0 is LSB
//               PRODUCT0..7      - registered product, bit 0 is LSB
// Config      : FOUR_BIT_MULTIPLIER_INPUT_REG_EN - when defined, operands are
//               registered before the array (latency 2 instead of 1).
// Revision    : 1.0 - initial release
// ============================================================================
module four_bit_multiplier
   import four_bit_multiplier_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic A0,
   input  logic A1,
   input  logic A2,
   input  logic A3,
   input  logic B0,
   input  logic B1,
   input  logic B2,
   input  logic B3,
   output logic PRODUCT0,
   output logic PRODUCT1,
   output logic PRODUCT2,
   output logic PRODUCT3,
   output logic PRODUCT4,
   output logic PRODUCT5,
   output logic PRODUCT6,
   output logic PRODUCT7
);

   logic [OPERAND_W-1:0] w_a;
   logic [OPERAND_W-1:0] w_b;
   logic [OPERAND_W-1:0] w_op_a;
   logic [OPERAND_W-1:0] w_op_b;

   assign w_a = {A3, A2, A1, A0};
   assign w_b = {B3, B2, B1, B0};

`ifdef FOUR_BIT_MULTIPLIER_INPUT_REG_EN
   logic [OPERAND_W-1:0] r_a;
   logic [OPERAND_W-1:0] r_b;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a <= '0;
         r_b <= '0;
      end else begin
         r_a <= w_a;
         r_b <= w_b;
      end
   end

   assign w_op_a = r_a;
   assign w_op_b = r_b;
`else
   assign w_op_a = w_a;
   assign w_op_b = w_b;
`endif

   // ------------------------------------------------------------------------
   // Partial products: w_pp[i][j] = A[j] & B[i], weight i+j.
   // ------------------------------------------------------------------------
   logic [OPERAND_W-1:0][OPERAND_W-1:0] w_pp;

   generate
      for (genvar i = 0; i < OPERAND_W; i++) begin : g_pp
         assign w_pp[i] = w_op_a & {OPERAND_W{w_op_b[i]}};
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Row 1: adds partial-product rows 0 and 1.
   // Cell k sits at weight k+1; the top cell is a half adder absorbing the
   // ripple carry into pp[1][3].
   // w_acc[r] holds the four running-sum bits left after row r, at weights
   // r+1 .. r+4 (the LSB of every row retires straight to the product).
   // ------------------------------------------------------------------------
   logic [OPERAND_W-1:0] w_r1_sum;
   logic [OPERAND_W-1:0] w_r1_cout;
   logic [3:1][OPERAND_W-1:0] w_acc;
   logic [3:2] w_low;

   mult_full_adder u_r1_c0 (
      .i_a(w_pp[0][1]), .i_b(w_pp[1][0]), .i_cin(1'b0),
      .o_sum(w_r1_sum[0]), .o_cout(w_r1_cout[0])
   );
   mult_full_adder u_r1_c1 (
      .i_a(w_pp[0][2]), .i_b(w_pp[1][1]), .i_cin(w_r1_cout[0]),
      .o_sum(w_r1_sum[1]), .o_cout(w_r1_cout[1])
   );
   mult_full_adder u_r1_c2 (
      .i_a(w_pp[0][3]), .i_b(w_pp[1][2]), .i_cin(w_r1_cout[1]),
      .o_sum(w_r1_sum[2]), .o_cout(w_r1_cout[2])
   );
   mult_full_adder u_r1_c3 (
      .i_a(w_pp[1][3]), .i_b(w_r1_cout[2]), .i_cin(1'b0),
      .o_sum(w_r1_sum[3]), .o_cout(w_r1_cout[3])
   );

   assign w_acc[1] = {w_r1_cout[3], w_r1_sum[3:1]};

   // ------------------------------------------------------------------------
   // Rows 2 and 3: add partial-product row r to the running sum. Cell 0 is a
   // half adder (nothing to carry in), cells 1..3 are full adders.
   // ------------------------------------------------------------------------
   generate
      for (genvar r = 2; r <= 3; r++) begin : g_row
         logic [OPERAND_W-1:0] w_sum;
         logic [OPERAND_W-1:0] w_cout;

         for (genvar k = 0; k < OPERAND_W; k++) begin : g_cell
            if (k == 0) begin : g_half
               mult_full_adder u_cell (
                  .i_a(w_acc[r-1][k]), .i_b(w_pp[r][k]), .i_cin(1'b0),
                  .o_sum(w_sum[k]), .o_cout(w_cout[k])
               );
            end else begin : g_full
               mult_full_adder u_cell (
                  .i_a(w_acc[r-1][k]), .i_b(w_pp[r][k]), .i_cin(w_cout[k-1]),
                  .o_sum(w_sum[k]), .o_cout(w_cout[k])
               );
            end
         end

         assign w_low[r] = w_sum[0];
         assign w_acc[r] = {w_cout[OPERAND_W-1], w_sum[OPERAND_W-1:1]};
      end
   endgenerate

   logic [PRODUCT_W-1:0] w_product;

   assign w_product = {w_acc[3], w_low[3], w_low[2], w_r1_sum[0], w_pp[0][0]};

   // ------------------------------------------------------------------------
   // Output register
   // ------------------------------------------------------------------------
   logic [PRODUCT_W-1:0] r_product;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_product <= PRODUCT_RESET;
      end else begin
         r_product <= w_product;
      end
   end

   assign PRODUCT0 = r_product[0];
   assign PRODUCT1 = r_product[1];
   assign PRODUCT2 = r_product[2];
   assign PRODUCT3 = r_product[3];
   assign PRODUCT4 = r_product[4];
   assign PRODUCT5 = r_product[5];
   assign PRODUCT6 = r_product[6];
   assign PRODUCT7 = r_product[7];

endmodule : four_bit_multiplier
`default_nettype wire

// File: tb/tb_four_bit_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : tb_four_bit_multiplier
// Description : Self-checking bench for four_bit_multiplier. Expected
//               products come from plain integer multiplication, delayed by
//               the configured latency through a queue.
// Config      : FOUR_BIT_MULTIPLIER_INPUT_REG_EN selects latency 2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_four_bit_multiplier;
   import four_bit_multiplier_pkg::*;

`ifdef FOUR_BIT_MULTIPLIER_INPUT_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   four_bit_multiplier_if mif ();

   always #5 clk = ~clk;

   four_bit_multiplier u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .A0      (mif.a[0]),
      .A1      (mif.a[1]),
      .A2      (mif.a[2]),
      .A3      (mif.a[3]),
      .B0      (mif.b[0]),
      .B1      (mif.b[1]),
      .B2      (mif.b[2]),
      .B3      (mif.b[3]),
      .PRODUCT0(mif.product[0]),
      .PRODUCT1(mif.product[1]),
      .PRODUCT2(mif.product[2]),
      .PRODUCT3(mif.product[3]),
      .PRODUCT4(mif.product[4]),
      .PRODUCT5(mif.product[5]),
      .PRODUCT6(mif.product[6]),
      .PRODUCT7(mif.product[7])
   );

   // Expected products in flight, oldest first.
   int          exp_q[$];
   logic [3:0]  last_a;
   logic [3:0]  last_b;

   // Drive one operand pair for one cycle; once the queue is LAT deep the
   // oldest expectation is due on the outputs.
   task automatic step(input logic [3:0] a, input logic [3:0] b,
                       input bit per_bit, input string tag);
      int exp;
      @(negedge clk);
      mif.a  = a;
      mif.b  = b;
      last_a = a;
      last_b = b;
      @(posedge clk);
      #1;
      exp_q.push_back(int'(a) * int'(b));
      if (exp_q.size() >= LAT) begin
         exp = exp_q.pop_front();
         if (per_bit) begin
            for (int k = 0; k < PRODUCT_W; k++) begin
               checks++;
               if (mif.product[k] !== exp[k]) begin
                  errors++;
                  $display("FAIL %s bit%0d: got %b expected %b (product got %0d expected %0d)",
                           tag, k, mif.product[k], exp[k], mif.product, exp);
               end
            end
         end else begin
            checks++;
            if (mif.product !== exp[7:0]) begin
               errors++;
               $display("FAIL %s: got %0d expected %0d", tag, mif.product, exp);
            end
         end
      end
   endtask

   // Hold the last operands until every queued expectation has been checked.
   task automatic flush(input string tag);
      repeat (LAT - 1) step(last_a, last_b, 1'b0, tag);
   endtask

   task automatic check_now(input logic [7:0] exp, input string tag);
      checks++;
      if (mif.product !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, mif.product, exp);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      mif.a = 4'd15;
      mif.b = 4'd15;
      repeat (3) begin
         @(posedge clk);
         #1;
         check_now(8'h00, "reset_hold");
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (LAT) @(posedge clk);
      #1;
      check_now(8'(15 * 15), "reset_release");
   endtask

   task automatic test_sweep();
      exp_q.delete();
      for (int i = 0; i < 256; i++) begin
         step(i[3:0], i[7:4], 1'b1, "sweep");
      end
      flush("sweep");
   endtask

   task automatic test_corners();
      logic [3:0] ca [5];
      logic [3:0] cb [5];
      ca = '{4'd0, 4'd1, 4'd8, 4'd15, 4'd15};
      cb = '{4'd13, 4'd9, 4'd8, 4'd1, 4'd15};
      for (int i = 0; i < 5; i++) begin
         exp_q.delete();
         step(ca[i], cb[i], 1'b0, "corner");
         flush("corner");
      end
      // Power-of-two multiplier gives a shifted copy of the other operand.
      for (int s = 0; s < 4; s++) begin
         logic [3:0] v;
         v = 4'($urandom_range(0, 15));
         exp_q.delete();
         step(v, 4'(1 << s), 1'b0, "pow2");
         flush("pow2");
      end
   endtask

   task automatic test_back_to_back();
      exp_q.delete();
      step(4'd3, 4'd5, 1'b0, "b2b");
      step(4'd7, 4'd6, 1'b0, "b2b");
      step(4'd2, 4'd2, 1'b0, "b2b");
      flush("b2b");
   endtask

   task automatic test_random();
      exp_q.delete();
      for (int i = 0; i < 64; i++) begin
         step(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b0, "random");
      end
      flush("random");
   endtask

   task automatic test_async_reset();
      exp_q.delete();
      step(4'd12, 4'd11, 1'b0, "async_pre");
      flush("async_pre");
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check_now(8'h00, "async_assert");
      @(posedge clk);
      #1;
      check_now(8'h00, "async_hold");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (LAT) @(posedge clk);
      #1;
      check_now(8'(12 * 11), "async_release");
   endtask

   task automatic test_glitch();
      exp_q.delete();
      step(4'd2, 4'd2, 1'b0, "glitch_pre");
      flush("glitch_pre");
      // Now just after an edge with product 4 settled.
      mif.a = 4'd5;
      mif.b = 4'd3;
      for (int t = 0; t < 6; t++) begin
         #1;
         mif.a[1] = ~mif.a[1];
         check_now(8'(2 * 2), "glitch_hold");
      end
      repeat (LAT) @(posedge clk);
      #1;
      check_now(8'(5 * 3), "glitch_capture");
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      mif.a  = 4'd0;
      mif.b  = 4'd0;
      last_a = 4'd0;
      last_b = 4'd0;
      test_reset();
      test_sweep();
      test_corners();
      test_back_to_back();
      test_random();
      test_async_reset();
      test_glitch();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_four_bit_multiplier
`default_nettype wire
